// File: rtl/hzu_scoreboard_pkg.sv
// Common definitions for the scoreboard hazard unit: instruction encoding,
// thread/register identifiers, stall-cause encoding and opcode classifiers
// shared by the top level and the per-thread scoreboard.
package hzu_scoreboard_pkg;

  localparam int THREAD_W = 2;
  localparam int REG_W    = 5;

  typedef logic [THREAD_W-1:0] threadid_t;
  typedef logic [REG_W-1:0]    regid_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MOV = 4'd3,
    OP_MUL = 4'd4,
    OP_LDB = 4'd5,
    OP_LDW = 4'd6,
    OP_STB = 4'd7,
    OP_STW = 4'd8,
    OP_BR  = 4'd9
  } op_t;

  typedef struct packed {
    regid_t dst;
    regid_t src1;
    regid_t src2;
  } rfields_t;

  typedef struct packed {
    rfields_t r;
  } fields_t;

  typedef struct packed {
    op_t     op;
    fields_t fields;
  } instr_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_FETCH = 2'd1,
    CAUSE_RAW   = 2'd2,
    CAUSE_WAW   = 2'd3
  } hzu_cause_t;

  // Stores carry their data in src2; branches compare src1 against src2.
  function automatic logic has_src2(input op_t op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_STB, OP_STW, OP_BR};
  endfunction

  function automatic logic has_dst(input op_t op);
    return op inside {OP_ADD, OP_SUB, OP_MOV, OP_MUL, OP_LDB, OP_LDW};
  endfunction

  function automatic logic is_load(input op_t op);
    return op inside {OP_LDB, OP_LDW};
  endfunction

  function automatic logic is_mul(input op_t op);
    return op == OP_MUL;
  endfunction

  function automatic logic is_alu(input op_t op);
    return op inside {OP_ADD, OP_SUB, OP_MOV};
  endfunction

endpackage

// File: rtl/hzu_scoreboard_sb_thread.sv
// Per-thread scoreboard: one countdown counter and one load-pending bit per
// architectural register, with three combinational busy lookups.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   set_alu/set_mul/set_ld   an issuing instr of this thread writes set_reg
//   set_reg                  destination register of the issuing instr
//   wb_valid, wb_reg         load writeback for this thread
//   q_src1/q_src2/q_dst      registers looked up this cycle
//   busy_src1/2, busy_dst    lookup results
module hzu_sb_thread #(
  parameter int NREGS     = 32,
  parameter int ALU_LAT   = 1,
  parameter int MUL_LAT   = 5,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_alu,
  input  logic                     set_mul,
  input  logic                     set_ld,
  input  logic [$clog2(NREGS)-1:0] set_reg,
  input  logic                     wb_valid,
  input  logic [$clog2(NREGS)-1:0] wb_reg,
  input  logic [$clog2(NREGS)-1:0] q_src1,
  input  logic [$clog2(NREGS)-1:0] q_src2,
  input  logic [$clog2(NREGS)-1:0] q_dst,
  output logic                     busy_src1,
  output logic                     busy_src2,
  output logic                     busy_dst
);

  localparam int RW = $clog2(NREGS);

  logic [CNT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] ld_pend;
  logic [NREGS-1:0] busy_vec;

  // A load completing this cycle can release its dependant in the same cycle
  // when the bypass is enabled.
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_vec[r] = (cnt[r] != '0) ||
                    (ld_pend[r] && !((WB_BYPASS != 0) && wb_valid && (wb_reg == RW'(r))));
    end
  end

  assign busy_src1 = busy_vec[q_src1];
  assign busy_src2 = busy_vec[q_src2];
  assign busy_dst  = busy_vec[q_dst];

  // Later assignments win: a fresh set overrides the decrement of that entry,
  // and a new load overrides a same-cycle writeback to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      ld_pend <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
      end
      if (set_alu) cnt[set_reg] <= CNT_W'(ALU_LAT - 1);
      if (set_mul) cnt[set_reg] <= CNT_W'(MUL_LAT - 1);
      if (wb_valid) ld_pend[wb_reg] <= 1'b0;
      if (set_ld) ld_pend[set_reg] <= 1'b1;
    end
  end

endmodule

// File: rtl/hzu_scoreboard.sv
// Per-thread register scoreboard hazard unit between decode and issue.
// Decides in zero cycles whether the presented instr issues, tracks in-flight
// writes per (thread, reg), and keeps saturating per-thread stall counters.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_thread/in_instr  presented decoded instr
//   itlb_miss, icache_miss    fetch misses for the presented instr
//   ld_wb_valid/_thread/_reg  load writeback
//   issue                     instr issues this cycle (combinational)
//   stall                     in_valid && !issue
//   stall_cause               0 none, 1 fetch miss, 2 RAW, 3 WAW
//   stall_cnt                 per-thread saturating stalled-cycle counts
module hzu_scoreboard
  import hzu_scoreboard_pkg::*;
#(
  parameter int NTHREADS  = 4,
  parameter int NREGS     = 32,
  parameter int ALU_LAT   = 1,
  parameter int MUL_LAT   = 5,
  parameter int WB_BYPASS = 1,
  parameter int STALLW    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  threadid_t                        in_thread,
  input  instr_t                           in_instr,
  input  logic                             itlb_miss,
  input  logic                             icache_miss,
  input  logic                             ld_wb_valid,
  input  threadid_t                        ld_wb_thread,
  input  logic [$clog2(NREGS)-1:0]         ld_wb_reg,
  output logic                             issue,
  output logic                             stall,
  output logic [1:0]                       stall_cause,
  output logic [NTHREADS-1:0][STALLW-1:0]  stall_cnt
);

  localparam int RW    = $clog2(NREGS);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [NTHREADS-1:0] busy_src1;
  logic [NTHREADS-1:0] busy_src2;
  logic [NTHREADS-1:0] busy_dst;
  logic                fetch_miss;
  logic                raw;
  logic                waw;
  logic                wr_dst;
  hzu_cause_t          cause;

  assign wr_dst = issue && has_dst(in_instr.op);

  for (genvar t = 0; t < NTHREADS; t++) begin : g_thread
    logic sel;
    assign sel = (in_thread == threadid_t'(t));

    hzu_sb_thread #(
      .NREGS     (NREGS),
      .ALU_LAT   (ALU_LAT),
      .MUL_LAT   (MUL_LAT),
      .WB_BYPASS (WB_BYPASS),
      .CNT_W     (CNT_W)
    ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .set_alu   (sel && wr_dst && is_alu(in_instr.op)),
      .set_mul   (sel && wr_dst && is_mul(in_instr.op)),
      .set_ld    (sel && wr_dst && is_load(in_instr.op)),
      .set_reg   (in_instr.fields.r.dst[RW-1:0]),
      .wb_valid  (ld_wb_valid && (ld_wb_thread == threadid_t'(t))),
      .wb_reg    (ld_wb_reg),
      .q_src1    (in_instr.fields.r.src1[RW-1:0]),
      .q_src2    (in_instr.fields.r.src2[RW-1:0]),
      .q_dst     (in_instr.fields.r.dst[RW-1:0]),
      .busy_src1 (busy_src1[t]),
      .busy_src2 (busy_src2[t]),
      .busy_dst  (busy_dst[t])
    );
  end

  assign fetch_miss = itlb_miss || icache_miss;
  assign raw = busy_src1[in_thread] || (has_src2(in_instr.op) && busy_src2[in_thread]);
  assign waw = has_dst(in_instr.op) && busy_dst[in_thread];

  assign issue = in_valid && !fetch_miss && !raw && !waw;
  assign stall = in_valid && !issue;

  always_comb begin
    cause = CAUSE_NONE;
    if (stall) begin
      if (fetch_miss) cause = CAUSE_FETCH;
      else if (raw)   cause = CAUSE_RAW;
      else            cause = CAUSE_WAW;
    end
  end

  assign stall_cause = cause;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt[in_thread] != '1)) begin
      stall_cnt[in_thread] <= stall_cnt[in_thread] + 1'b1;
    end
  end

endmodule

// File: tb/tb_hzu_scoreboard.sv
// Bench for hzu_scoreboard: two instances share stimulus, one with the load
// bypass and 16-bit counters, one without bypass and 4-bit counters.
// A reference model tracks, per config, the cycle from which each register
// becomes readable plus a set of pending loads.
module tb_hzu_scoreboard;
  import hzu_scoreboard_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  threadid_t  in_thread;
  instr_t     in_instr;
  logic       itlb_miss;
  logic       icache_miss;
  logic       ld_wb_valid;
  threadid_t  ld_wb_thread;
  logic [4:0] ld_wb_reg;

  logic            issue_a, stall_a, issue_b, stall_b;
  logic [1:0]      cause_a, cause_b;
  logic [3:0][15:0] sc_a;
  logic [3:0][3:0]  sc_b;

  hzu_scoreboard #(.WB_BYPASS(1), .STALLW(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_thread(in_thread),
    .in_instr(in_instr), .itlb_miss(itlb_miss), .icache_miss(icache_miss),
    .ld_wb_valid(ld_wb_valid), .ld_wb_thread(ld_wb_thread), .ld_wb_reg(ld_wb_reg),
    .issue(issue_a), .stall(stall_a), .stall_cause(cause_a), .stall_cnt(sc_a));

  hzu_scoreboard #(.WB_BYPASS(0), .STALLW(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_thread(in_thread),
    .in_instr(in_instr), .itlb_miss(itlb_miss), .icache_miss(icache_miss),
    .ld_wb_valid(ld_wb_valid), .ld_wb_thread(ld_wb_thread), .ld_wb_reg(ld_wb_reg),
    .issue(issue_b), .stall(stall_b), .stall_cause(cause_b), .stall_cnt(sc_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Reference model state, index [config][thread][reg].
  int unsigned ready_at [2][4][32];
  bit          ldp      [2][4][32];
  int unsigned scnt     [2][4];
  int unsigned cyc = 0;
  bit          m_wv;
  int          m_wt, m_wr;

  localparam int          BYP     [2] = '{1, 0};
  localparam int unsigned SAT_MAX [2] = '{65535, 15};

  bit         obs_iss_a, obs_iss_b;
  logic [1:0] obs_cause_a;
  logic [3:0][15:0] obs_sc_a;
  logic [3:0][3:0]  obs_sc_b;

  function automatic bit m_src2(input op_t op);
    return op == OP_ADD || op == OP_SUB || op == OP_MUL ||
           op == OP_STB || op == OP_STW || op == OP_BR;
  endfunction

  // Cycles until a dependant may issue; -1 marks a variable-latency load,
  // 0 marks an op that writes no register.
  function automatic int m_lat(input op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_MOV: return 1;
      OP_MUL:                 return 5;
      OP_LDB, OP_LDW:         return -1;
      default:                return 0;
    endcase
  endfunction

  function automatic bit m_busy(input int c, input int t, input int r);
    bit bypassed;
    bypassed = (BYP[c] != 0) && m_wv && (m_wt == t) && (m_wr == r);
    return (cyc < ready_at[c][t][r]) || (ldp[c][t][r] && !bypassed);
  endfunction

  task automatic step(input bit v, input int th, input op_t op, input int d,
                      input int s1, input int s2, input bit tm, input bit im,
                      input bit wv, input int wt, input int wr, input bit r);
    bit e_iss [2];
    bit e_stl [2];
    int e_cau [2];
    @(negedge clk);
    rst = r; in_valid = v; in_thread = threadid_t'(th);
    in_instr.op = op;
    in_instr.fields.r.dst  = regid_t'(d);
    in_instr.fields.r.src1 = regid_t'(s1);
    in_instr.fields.r.src2 = regid_t'(s2);
    itlb_miss = tm; icache_miss = im;
    ld_wb_valid = wv; ld_wb_thread = threadid_t'(wt); ld_wb_reg = 5'(wr);
    m_wv = wv; m_wt = wt; m_wr = wr;
    #1;
    for (int c = 0; c < 2; c++) begin
      bit fm, raw, waw;
      fm  = tm || im;
      raw = m_busy(c, th, s1) || (m_src2(op) && m_busy(c, th, s2));
      waw = (m_lat(op) != 0) && m_busy(c, th, d);
      e_iss[c] = v && !fm && !raw && !waw;
      e_stl[c] = v && !e_iss[c];
      e_cau[c] = !e_stl[c] ? 0 : fm ? 1 : raw ? 2 : 3;
    end
    chk($sformatf("issue_a@%0d", cyc), 32'(issue_a), 32'(e_iss[0]));
    chk($sformatf("stall_a@%0d", cyc), 32'(stall_a), 32'(e_stl[0]));
    chk($sformatf("cause_a@%0d", cyc), 32'(cause_a), 32'(e_cau[0]));
    chk($sformatf("issue_b@%0d", cyc), 32'(issue_b), 32'(e_iss[1]));
    chk($sformatf("stall_b@%0d", cyc), 32'(stall_b), 32'(e_stl[1]));
    chk($sformatf("cause_b@%0d", cyc), 32'(cause_b), 32'(e_cau[1]));
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("scnt_a[%0d]@%0d", t, cyc), 32'(sc_a[t]), scnt[0][t]);
      chk($sformatf("scnt_b[%0d]@%0d", t, cyc), 32'(sc_b[t]), scnt[1][t]);
    end
    obs_iss_a = issue_a; obs_iss_b = issue_b; obs_cause_a = cause_a;
    obs_sc_a = sc_a; obs_sc_b = sc_b;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (r) begin
        for (int t = 0; t < 4; t++) begin
          scnt[c][t] = 0;
          for (int k = 0; k < 32; k++) begin
            ready_at[c][t][k] = 0;
            ldp[c][t][k] = 1'b0;
          end
        end
      end else begin
        if (wv) ldp[c][wt][wr] = 1'b0;
        if (e_iss[c]) begin
          if (m_lat(op) > 0) ready_at[c][th][d] = cyc + int'(m_lat(op));
          else if (m_lat(op) < 0) ldp[c][th][d] = 1'b1;
        end
        if (e_stl[c] && scnt[c][th] < SAT_MAX[c]) scnt[c][th]++;
      end
    end
    cyc++;
  endtask

  task automatic idle(input bit r);
    step(1'b0, 0, OP_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, r);
  endtask

  task automatic wb(input int t, input int rg);
    step(1'b0, 0, OP_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b1, t, rg, 1'b0);
  endtask

  task automatic op3(input int th, input op_t op, input int d, input int s1,
                     input int s2, input bit im);
    step(1'b1, th, op, d, s1, s2, 1'b0, im, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_thread = '0; in_instr = '0;
    itlb_miss = 1'b0; icache_miss = 1'b0;
    ld_wb_valid = 1'b0; ld_wb_thread = '0; ld_wb_reg = '0;
    m_wv = 1'b0; m_wt = 0; m_wr = 0;
    for (int c = 0; c < 2; c++)
      for (int t = 0; t < 4; t++) begin
        scnt[c][t] = 0;
        for (int k = 0; k < 32; k++) begin
          ready_at[c][t][k] = 0;
          ldp[c][t][k] = 1'b0;
        end
      end

    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    chk("rst_issue", 32'(obs_iss_a), 32'd0);
    chk("rst_scnt0", 32'(obs_sc_a[0]), 32'd0);

    // Back-to-back ALU dependants.
    op3(0, OP_ADD, 3, 1, 2, 1'b0);
    chk("alu_first", 32'(obs_iss_a), 32'd1);
    op3(0, OP_ADD, 4, 3, 1, 1'b0);
    chk("alu_dep", 32'(obs_iss_a), 32'd1);
    idle(1'b0);
    chk("alu_scnt0", 32'(obs_sc_a[0]), 32'd0);

    // Multiply latency: four RAW stalls then issue.
    op3(0, OP_MUL, 5, 1, 2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      op3(0, OP_ADD, 6, 5, 1, 1'b0);
      chk($sformatf("mul_dep_iss%0d", k), 32'(obs_iss_a), 32'(k == 4));
      if (k < 4) chk($sformatf("mul_dep_cause%0d", k), 32'(obs_cause_a), 32'd2);
    end

    // Load dependant released by writeback, with and without bypass.
    op3(1, OP_LDW, 7, 1, 0, 1'b0);
    for (int k = 0; k < 3; k++) op3(1, OP_ADD, 8, 7, 1, 1'b0);
    step(1'b1, 1, OP_ADD, 8, 7, 1, 1'b0, 1'b0, 1'b1, 1, 7, 1'b0);
    chk("wb_byp_a", 32'(obs_iss_a), 32'd1);
    chk("wb_byp_b", 32'(obs_iss_b), 32'd0);
    op3(1, OP_ADD, 8, 7, 1, 1'b0);
    chk("wb_next_b", 32'(obs_iss_b), 32'd1);

    // Thread independence.
    op3(0, OP_LDW, 7, 1, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      op3(0, OP_ADD, 9, 7, 1, 1'b0);
      chk("indep_t0", 32'(obs_iss_a), 32'd0);
      op3(1, OP_ADD, 7, 1, 2, 1'b0);
      chk("indep_t1", 32'(obs_iss_a), 32'd1);
    end
    wb(0, 7);

    // WAW against a pending load, then fetch miss outranking RAW.
    op3(0, OP_LDW, 2, 1, 0, 1'b0);
    op3(0, OP_MOV, 2, 1, 0, 1'b0);
    chk("waw_cause", 32'(obs_cause_a), 32'd3);
    op3(0, OP_ADD, 10, 2, 1, 1'b1);
    chk("miss_cause", 32'(obs_cause_a), 32'd1);
    wb(0, 2);

    // Saturation of the narrow counter.
    op3(2, OP_LDW, 11, 1, 0, 1'b0);
    for (int k = 0; k < 20; k++) op3(2, OP_ADD, 12, 11, 1, 1'b0);
    idle(1'b0);
    chk("sat_b", 32'(obs_sc_b[2]), 32'd15);
    chk("sat_a", 32'(obs_sc_a[2]), 32'd20);
    wb(2, 11);

    // Reset while a load is pending.
    op3(3, OP_LDW, 13, 1, 0, 1'b0);
    idle(1'b1);
    op3(3, OP_ADD, 14, 13, 1, 1'b0);
    chk("rst_ld_a", 32'(obs_iss_a), 32'd1);
    chk("rst_ld_b", 32'(obs_iss_b), 32'd1);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      bit r;
      r = ($urandom_range(0, 499) == 0);
      step(!r && ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
           op_t'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
